// File: rtl/fx_bus_arb_if.sv
// fx_bus_arb_if
//   Groups the two master request channels and the cfg_reg-side fx bus that
//   fx_bus_arb arbitrates between.
//   Master A / master B channels (x = a, b):
//     x_req    request, held with x_we/x_addr/x_wdata until x_ack
//     x_we     1 = write, 0 = read
//     x_addr   transaction address
//     x_wdata  write data
//     x_ack    one-cycle completion pulse
//     x_rdata  read data, valid with x_ack and held until the next read ack
//   fx bus toward cfg_reg:
//     fx_wr / fx_waddr / fx_data   write strobe, address, data
//     fx_rd / fx_raddr             read strobe, address
//     fx_q                         read data, RD_LAT cycles after fx_rd
//   arb_busy   high whenever the arbiter is not idle
//   Modports: slave = arbiter side, master = requesters plus cfg_reg model side.
interface fx_bus_arb_if #(
    parameter int AW = 22,
    parameter int DW = 8
);
    logic          a_req;
    logic          a_we;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_wdata;
    logic          a_ack;
    logic [DW-1:0] a_rdata;

    logic          b_req;
    logic          b_we;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_wdata;
    logic          b_ack;
    logic [DW-1:0] b_rdata;

    logic          fx_wr;
    logic [AW-1:0] fx_waddr;
    logic [DW-1:0] fx_data;
    logic          fx_rd;
    logic [AW-1:0] fx_raddr;
    logic [DW-1:0] fx_q;

    logic          arb_busy;

    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        output a_ack, a_rdata,
        input  b_req, b_we, b_addr, b_wdata,
        output b_ack, b_rdata,
        output fx_wr, fx_waddr, fx_data, fx_rd, fx_raddr,
        input  fx_q,
        output arb_busy
    );

    modport master (
        output a_req, a_we, a_addr, a_wdata,
        input  a_ack, a_rdata,
        output b_req, b_we, b_addr, b_wdata,
        input  b_ack, b_rdata,
        input  fx_wr, fx_waddr, fx_data, fx_rd, fx_raddr,
        output fx_q,
        input  arb_busy
    );
endinterface

// File: rtl/fx_bus_arb.sv
// fx_bus_arb
//   Round-robin arbiter giving two masters (A = host/FX path, B = on-chip
//   sequencer) single-transaction access to the cfg_reg fx bus. One command
//   is in flight at a time: IDLE -> ISSUE -> [WAIT x RD_LAT] -> ACK -> IDLE.
//   Ports:
//     clk_sys  system clock, rising edge
//     rst_n    synchronous active-low reset
//     bus      fx_bus_arb_if.slave: A/B request channels, fx bus, arb_busy
//   Parameters: AW address width, DW data width, RD_LAT read latency (1..7).
module fx_bus_arb #(
    parameter int AW     = 22,
    parameter int DW     = 8,
    parameter int RD_LAT = 1
) (
    input  logic         clk_sys,
    input  logic         rst_n,
    fx_bus_arb_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_ACK   = 2'd3
    } state_t;

    localparam logic [2:0] LAT = 3'(RD_LAT);

    state_t        state_q, state_d;
    logic          rr_last_q, rr_last_d;   // 0 = A, 1 = B
    logic          win_q, win_d;           // 0 = A, 1 = B
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [DW-1:0] a_rdata_q, a_rdata_d;
    logic [DW-1:0] b_rdata_q, b_rdata_d;
    logic          pick_b;

    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            rr_last_q <= 1'b1;   // last = B, so A wins the first tie
            win_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            cnt_q     <= '0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            rr_last_q <= rr_last_d;
            win_q     <= win_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            cnt_q     <= cnt_d;
            a_rdata_q <= a_rdata_d;
            b_rdata_q <= b_rdata_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        rr_last_d = rr_last_q;
        win_d     = win_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        a_rdata_d = a_rdata_q;
        b_rdata_d = b_rdata_q;
        pick_b    = 1'b0;

        case (state_q)
            S_IDLE: begin
                // On a tie the master that did not win the last tie goes.
                if (bus.a_req && bus.b_req) pick_b = ~rr_last_q;
                else                        pick_b = bus.b_req;
                if (bus.a_req || bus.b_req) begin
                    win_d   = pick_b;
                    if (bus.a_req && bus.b_req) rr_last_d = pick_b;
                    we_d    = pick_b ? bus.b_we    : bus.a_we;
                    addr_d  = pick_b ? bus.b_addr  : bus.a_addr;
                    wdata_d = pick_b ? bus.b_wdata : bus.a_wdata;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (we_q) begin
                    state_d = S_ACK;
                end else begin
                    cnt_d   = LAT;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // Last wait cycle is the one in which fx_q is valid.
                if (cnt_q == 3'd1) begin
                    if (win_q) b_rdata_d = bus.fx_q;
                    else       a_rdata_d = bus.fx_q;
                    state_d = S_ACK;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Address/data outputs come straight from the command register, so they
    // hold their last value while idle; strobes exist only in ISSUE.
    assign bus.fx_wr    = (state_q == S_ISSUE) &&  we_q;
    assign bus.fx_rd    = (state_q == S_ISSUE) && !we_q;
    assign bus.fx_waddr = addr_q;
    assign bus.fx_raddr = addr_q;
    assign bus.fx_data  = wdata_q;
    assign bus.a_ack    = (state_q == S_ACK) && !win_q;
    assign bus.b_ack    = (state_q == S_ACK) &&  win_q;
    assign bus.a_rdata  = a_rdata_q;
    assign bus.b_rdata  = b_rdata_q;
    assign bus.arb_busy = (state_q != S_IDLE);
endmodule
